// File: rtl/mips_mem_responder_pkg.sv
// Shared types and helpers for the multicycle MIPS memory responder:
// FSM state encoding, wait-counter width and the byte-to-word offset function.
package mips_mem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_WAIT    = 2'd1,
        MEM_RESPOND = 2'd2
    } mem_state_t;

    // Word offset from the base; the subtraction wraps in 32 bits.
    function automatic logic [WORD_W-1:0] word_offset(input logic [WORD_W-1:0] addr,
                                                     input logic [WORD_W-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Request/response bus between the MIPS core memory port and the memory responder.
interface mips_mem_responder_if
    import mips_mem_responder_pkg::*;
    ;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/mips_word_ram.sv
// Single-port word RAM: synchronous write, synchronous read into a clearable
// output register that doubles as the responder's read-data holding register.
module mips_word_ram
    import mips_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              cclk,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge cclk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge cclk) begin
        if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory target for the multicycle MIPS core with a
// valid/ready handshake and programmable wait states. Optional MIPS_MEM_ERR_CHECK_EN
// flags misaligned or out-of-range accesses on rsp_err and suppresses their effect.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int              DEPTH_WORDS = 256,
    parameter int              WAIT_STATES = 1,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 cclk,
    input  logic                 rstb,
    mips_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

    mem_state_t        state;
    logic [WAIT_W-1:0] cnt;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic              lat_we;
    logic [AW-1:0]     lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic              lat_err;

    logic [WORD_W-1:0] off;
    logic [AW-1:0]     in_idx;
    logic              in_err;
    logic              accept;
    logic              commit;
    logic              cur_we;
    logic [AW-1:0]     cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_err;

    assign off    = word_offset(bus.req_addr, BASE_ADDR);
    assign in_idx = off[AW-1:0];

`ifdef MIPS_MEM_ERR_CHECK_EN
    assign in_err = (bus.req_addr[1:0] != 2'b00) || (off >= WORD_W'(DEPTH_WORDS));
`else
    // Byte lane and high offset bits are deliberately discarded: addresses wrap.
    logic unused_bits;
    assign unused_bits = ^{off[WORD_W-1:AW], bus.req_addr[1:0]};
    assign in_err      = 1'b0;
`endif

    assign bus.req_ready = rstb && (state == MEM_IDLE);
    assign bus.busy      = (state != MEM_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // With zero wait states the commit lands on the accept edge, so use live inputs.
    assign cur_we    = (state == MEM_IDLE) ? bus.req_we    : lat_we;
    assign cur_idx   = (state == MEM_IDLE) ? in_idx        : lat_idx;
    assign cur_wdata = (state == MEM_IDLE) ? bus.req_wdata : lat_wdata;
    assign cur_err   = (state == MEM_IDLE) ? in_err        : lat_err;

    assign commit = rstb &&
                    (((state == MEM_IDLE) && accept && (WAIT_STATES == 0)) ||
                     ((state == MEM_WAIT) && (cnt == '0)));

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state       <= MEM_IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= commit;
            if (commit) begin
                rsp_err_q <= cur_err;
            end
            case (state)
                MEM_IDLE: begin
                    if (accept) begin
                        cnt   <= CNT_LOAD;
                        state <= (WAIT_STATES == 0) ? MEM_RESPOND : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (cnt == '0) begin
                        state <= MEM_RESPOND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MEM_RESPOND: state <= MEM_IDLE;
                default:     state <= MEM_IDLE;
            endcase
        end
    end

    always_ff @(posedge cclk) begin
        if (accept) begin
            lat_we    <= bus.req_we;
            lat_idx   <= in_idx;
            lat_wdata <= bus.req_wdata;
            lat_err   <= in_err;
        end
    end

    mips_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .cclk  (cclk),
        .we    (commit && cur_we && !cur_err),
        .re    (commit && !cur_we && !cur_err),
        .clr   (!rstb || (commit && cur_err)),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (bus.rsp_rdata)
    );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench: two responders (1 wait state / depth 16, 0 wait states / depth 256).
module tb_mips_mem_responder;

    localparam int WS_A = 1;
    localparam int WS_B = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic cclk = 1'b0;
    logic rstb = 1'b0;
    always #5 cclk = ~cclk;

    mips_mem_responder_if bus_a ();
    mips_mem_responder_if bus_b ();

    mips_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(WS_A), .BASE_ADDR(32'h0)) dut_a (
        .cclk (cclk), .rstb (rstb), .bus (bus_a)
    );
    mips_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_B), .BASE_ADDR(32'h0)) dut_b (
        .cclk (cclk), .rstb (rstb), .bus (bus_b)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   acc_a  = 0;
    int   acc_b  = 0;
    int   acc_b_prev = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever a responder presents rsp_valid.
    always @(negedge cclk) begin
        cyc++;
        if (rstb) begin
            if (bus_a.rsp_valid) begin
                if (qa.size() == 0) begin
                    chk("a_rsp_pending", 32'(qa.size() > 0), 32'd1);
                end else begin
                    ea = qa.pop_front();
                    chk("a_rdata", bus_a.rsp_rdata, ea.rdata);
                    chk("a_err", 32'(bus_a.rsp_err), 32'(ea.err));
                    chk("a_latency", 32'(cyc - acc_a), 32'(WS_A + 1));
                    chk("a_ready_in_rsp", 32'(bus_a.req_ready), 32'd0);
                end
            end
            if (bus_b.rsp_valid) begin
                if (qb.size() == 0) begin
                    chk("b_rsp_pending", 32'(qb.size() > 0), 32'd1);
                end else begin
                    eb = qb.pop_front();
                    chk("b_rdata", bus_b.rsp_rdata, eb.rdata);
                    chk("b_err", 32'(bus_b.rsp_err), 32'(eb.err));
                    chk("b_latency", 32'(cyc - acc_b), 32'(WS_B + 1));
                    chk("b_ready_in_rsp", 32'(bus_b.req_ready), 32'd0);
                end
            end
            if (bus_a.req_valid && bus_a.req_ready) acc_a = cyc;
            if (bus_b.req_valid && bus_b.req_ready) begin
                acc_b_prev = acc_b;
                acc_b      = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge cclk);
        #1;
    endtask

    task automatic wait_accept(input bit b);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge cclk);
            if (b) got = bus_b.req_valid && bus_b.req_ready;
            else   got = bus_a.req_valid && bus_a.req_ready;
        end
        chk(b ? "b_accept" : "a_accept", 32'(got), 32'd1);
        @(posedge cclk);
        #1;
    endtask

    task automatic drive(input bit b, input bit v, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (b) begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wdata;
        end else begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
        end
    endtask

    task automatic issue(input bit b, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
        if (b) qb.push_back('{rdata: exp_rd, err: exp_err});
        else   qa.push_back('{rdata: exp_rd, err: exp_err});
        drive(b, 1'b1, we, addr, wdata);
        wait_accept(b);
        drive(b, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_ready"},  32'(bus_a.req_ready), 32'd0);
        chk({tag, "_a_valid"},  32'(bus_a.rsp_valid), 32'd0);
        chk({tag, "_a_rdata"},  bus_a.rsp_rdata, 32'd0);
        chk({tag, "_a_err"},    32'(bus_a.rsp_err), 32'd0);
        chk({tag, "_a_busy"},   32'(bus_a.busy), 32'd0);
        chk({tag, "_b_ready"},  32'(bus_b.req_ready), 32'd0);
        chk({tag, "_b_valid"},  32'(bus_b.rsp_valid), 32'd0);
        chk({tag, "_b_rdata"},  bus_b.rsp_rdata, 32'd0);
        chk({tag, "_b_busy"},   32'(bus_b.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rstb = 1'b0;

        // Reset values after two cycles low, ready right after release.
        repeat (2) @(posedge cclk);
        @(negedge cclk);
        check_reset_outputs("rst");
        @(posedge cclk);
        #1 rstb = 1'b1;
        @(negedge cclk);
        chk("a_ready_after_rst", 32'(bus_a.req_ready), 32'd1);
        chk("b_ready_after_rst", 32'(bus_b.req_ready), 32'd1);
        idle(1);

        // One wait state: write then read back; writes leave rdata unchanged.
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        issue(1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        issue(1'b0, 1'b1, 32'h20, 32'h11111111, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 1'b1, 32'h00, 32'h0BADF00D, 32'hDEADBEEF, 1'b0);

        // Zero wait states with req_valid held across two reads.
        issue(1'b1, 1'b1, 32'h0, 32'hCAFE0000, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'h4, 32'hCAFE0004, 32'h0, 1'b0);
        qb.push_back('{rdata: 32'hCAFE0000, err: 1'b0});
        qb.push_back('{rdata: 32'hCAFE0004, err: 1'b0});
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        wait_accept(1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        wait_accept(1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);
        chk("b_accept_spacing", 32'(acc_b - acc_b_prev), 32'd2);

`ifdef MIPS_MEM_ERR_CHECK_EN
        issue(1'b1, 1'b1, 32'h400, 32'h0000_00A5, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h0,   32'h0,         32'hCAFE0000, 1'b0);
`else
        // 0x400 is word 256, which wraps onto word 0.
        issue(1'b1, 1'b1, 32'h400, 32'h0000_00A5, 32'hCAFE0004, 1'b0);
        issue(1'b1, 1'b0, 32'h0,   32'h0,         32'h0000_00A5, 1'b0);
`endif

        // Reset lands on the commit edge of a pending write: nothing commits.
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        wait_accept(1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge cclk);
        chk("a_busy_in_wait", 32'(bus_a.busy), 32'd1);
        rstb = 1'b0;
        @(posedge cclk);
        @(negedge cclk);
        check_reset_outputs("abort");
        @(posedge cclk);
        #1 rstb = 1'b1;
        idle(3);
        issue(1'b0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

`ifdef MIPS_MEM_ERR_CHECK_EN
        issue(1'b0, 1'b0, 32'h13, 32'h0,         32'h0, 1'b1);
        issue(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF,  32'h0, 1'b1);
        issue(1'b0, 1'b0, 32'h00, 32'h0,         32'h0BADF00D, 1'b0);
`else
        // Byte lane ignored: 0x13 reads word 4.
        issue(1'b0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 1'b0, 32'h00, 32'h0, 32'h0BADF00D, 1'b0);
`endif

        idle(5);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
